// File: rtl/clock_generation_if.sv
// Control, rate and generated-clock signals of clock_generation.
// The bench or recovery path drives the master side.
interface clock_generation_if #(
  parameter int W = 8
);
  logic         generation_en_i;
  logic         clear_state_i;
  logic         locked_in_i;
  logic [W-1:0] high_rate_i;
  logic [W-1:0] low_rate_i;
  logic         align_en_i;
  logic         align_event_i;
  logic         generated_clk_o;
  logic         rising_event_o;
  logic         falling_event_o;
  logic         running_o;
  logic         phase_corrected_o;
  logic         rate_error_o;

  modport master (
    output generation_en_i, clear_state_i,
    output locked_in_i, high_rate_i,
    output low_rate_i, align_en_i,
    output align_event_i,
    input  generated_clk_o, rising_event_o,
    input  falling_event_o, running_o,
    input  phase_corrected_o, rate_error_o
  );

  modport slave (
    input  generation_en_i, clear_state_i,
    input  locked_in_i, high_rate_i,
    input  low_rate_i, align_en_i,
    input  align_event_i,
    output generated_clk_o, rising_event_o,
    output falling_event_o, running_o,
    output phase_corrected_o, rate_error_o
  );
endinterface

// File: rtl/clock_generation.sv
// Glitch-free clock regenerator driven by recovered high/low rates.
// Rates are shadowed at period boundaries; optional phase re-anchoring.
package common_p;
  typedef struct packed {
    logic clk;
    logic sync_rst;
  } clk_dom_s;
endpackage

package clks_alot_p;
  localparam int RATE_COUNTER_WIDTH = 8;
endpackage

module clock_generation
  import common_p::*;
#(
  parameter int RATE_COUNTER_WIDTH =
    clks_alot_p::RATE_COUNTER_WIDTH
) (
  input clk_dom_s            sys_dom_i,
  clock_generation_if.slave  gen
);
  localparam int W = RATE_COUNTER_WIDTH;
  localparam logic [W-1:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE, HIGH, LOW
  } state_e;

  logic         clk;
  logic         rst_n;
  state_e       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W-1:0] lo_q, lo_d;
  logic         clk_q, clk_d;
  logic         rise_q, rise_d;
  logic         fall_q, fall_d;
  logic         pc_q, pc_d;
  logic         err_q, err_d;
  logic         req, go, bad, align;

  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.sync_rst;

  assign req   = gen.generation_en_i
               & gen.locked_in_i;
  assign go    = req
               & (gen.high_rate_i != '0)
               & (gen.low_rate_i != '0);
  assign bad   = req & ~go;
  assign align = gen.align_en_i
               & gen.align_event_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    pc_d    = 1'b0;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          hi_d    = gen.high_rate_i;
          lo_d    = gen.low_rate_i;
          cnt_d   = gen.high_rate_i - ONE;
          state_d = HIGH;
          rise_d  = 1'b1;
        end else if (bad) begin
          err_d = 1'b1;
        end
      end
      HIGH: begin
        if (align) begin
          cnt_d = hi_q - ONE;
          pc_d  = 1'b1;
        end else if (cnt_q == '0) begin
          cnt_d   = lo_q - ONE;
          state_d = LOW;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      LOW: begin
        if (align && cnt_q != '0) begin
          cnt_d   = hi_q - ONE;
          state_d = HIGH;
          rise_d  = 1'b1;
          pc_d    = 1'b1;
        end else if (cnt_q == '0) begin
          if (go) begin
            hi_d    = gen.high_rate_i;
            lo_d    = gen.low_rate_i;
            cnt_d   = gen.high_rate_i - ONE;
            state_d = HIGH;
            rise_d  = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = IDLE;
            err_d   = err_q | bad;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
    clk_d = (state_d == HIGH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || gen.clear_state_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      clk_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      pc_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      clk_q   <= clk_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  assign gen.generated_clk_o   = clk_q;
  assign gen.rising_event_o    = rise_q;
  assign gen.falling_event_o   = fall_q;
  assign gen.running_o         = (state_q != IDLE);
  assign gen.phase_corrected_o = pc_q;
  assign gen.rate_error_o      = err_q;
endmodule
